// File: rtl/button_input.sv
// button_input: synchronises a raw button, debounces it with a four-state FSM and
// emits a clean level plus single-cycle press / release / long-press pulses.
module button_input #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press,
    output logic released,
    output logic long_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {RELEASED, PRESS_DEB, PRESSED, RELEASE_DEB} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [HW-1:0] hold, hold_n;
    logic          s1, s2;
    logic          fired, fired_n;
    logic          level_n, press_n, release_n, long_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RELEASED;
            s1         <= 1'b0;
            s2         <= 1'b0;
            cnt        <= '0;
            hold       <= '0;
            fired      <= 1'b0;
            level      <= 1'b0;
            press      <= 1'b0;
            released   <= 1'b0;
            long_press <= 1'b0;
        end else begin
            state      <= state_n;
            s1         <= btn;
            s2         <= s1;
            cnt        <= cnt_n;
            hold       <= hold_n;
            fired      <= fired_n;
            level      <= level_n;
            press      <= press_n;
            released   <= release_n;
            long_press <= long_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            RELEASED:  state_n = s2 ? PRESS_DEB : RELEASED;
            PRESS_DEB: state_n = !s2 ? RELEASED : (cnt == CNT_LAST ? PRESSED : PRESS_DEB);
            PRESSED:   state_n = s2 ? PRESSED : RELEASE_DEB;
            default:   state_n = s2 ? PRESSED : (cnt == CNT_LAST ? RELEASED : RELEASE_DEB);
        endcase
    end

    // fired remembers that this press already produced its long_press
    always_comb begin
        cnt_n     = cnt;
        hold_n    = hold;
        fired_n   = fired;
        level_n   = level;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        case (state)
            RELEASED: begin
                if (s2) cnt_n = CW'(1);
            end
            PRESS_DEB: begin
                if (!s2) cnt_n = '0;
                else if (cnt == CNT_LAST) begin
                    level_n = 1'b1;
                    press_n = 1'b1;
                    hold_n  = '0;
                    fired_n = 1'b0;
                end else cnt_n = cnt + 1'b1;
            end
            PRESSED: begin
                if (!s2) cnt_n = CW'(1);
                else if (hold == HOLD_LAST) begin
                    long_n  = !fired;
                    fired_n = 1'b1;
                end else hold_n = hold + 1'b1;
            end
            default: begin
                if (s2) cnt_n = '0;
                else if (cnt == CNT_LAST) begin
                    level_n   = 1'b0;
                    release_n = 1'b1;
                end else cnt_n = cnt + 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_button_input.sv
// tb_button_input: directed scenarios plus random button activity, checked every
// cycle against a run-length reference model of the debouncer.
module tb_button_input;
    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic level, press, released, long_press;
    int   n_vec = 0;
    int   n_err = 0;

    // reference model: two-stage sync, then count consecutive samples disagreeing with level
    logic m_s1, m_s2, e_level, e_press, e_rel, e_long, m_fired;
    int   run, held;

    button_input #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
        .clk(clk), .rst(rst), .btn(btn), .level(level),
        .press(press), .released(released), .long_press(long_press)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0; e_level = 0; e_press = 0; e_rel = 0; e_long = 0;
        m_fired = 0; run = 0; held = 0;
    endfunction

    function automatic void model_edge(input logic b);
        e_press = 0; e_rel = 0; e_long = 0;
        if (m_s2 != e_level) begin
            run++;
            if (run == DEB) begin
                e_level = m_s2;
                run = 0;
                if (m_s2) begin
                    e_press = 1; held = 0; m_fired = 0;
                end else e_rel = 1;
            end
        end else if (run != 0) run = 0;
        else if (e_level) begin
            if (held == LONG - 1) begin
                if (!m_fired) begin e_long = 1; m_fired = 1; end
            end else held++;
        end
        m_s2 = m_s1;
        m_s1 = b;
    endfunction

    task automatic step(input logic b);
        btn = b;
        @(posedge clk);
        model_edge(b);
        #1;
        chk("level", level, e_level);
        chk("press", press, e_press);
        chk("release", released, e_rel);
        chk("long_press", long_press, e_long);
        chk("exclusive", (int'(press) + int'(released) + int'(long_press)) <= 1, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        model_reset();
        chk("rst_level", level, 1'b0);
        chk("rst_press", press, 1'b0);
        chk("rst_release", released, 1'b0);
        chk("rst_long", long_press, 1'b0);
        #2;
        rst = 0;
    endtask

    initial begin
        logic pat [12];
        logic b;
        int   len;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_level", level, 1'b0);
        chk("init_press", press, 1'b0);
        chk("init_release", released, 1'b0);
        chk("init_long", long_press, 1'b0);
        rst = 0;
        // clean press and release
        for (int i = 1; i <= 10; i++) begin
            step(1);
            chk("s1_press_at_6", press, i == 6);
            chk("s1_level_from_6", level, i >= 6);
        end
        for (int i = 1; i <= 10; i++) begin
            step(0);
            chk("s1_release_at_6", released, i == 6);
        end
        // bounce on press
        pat = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        for (int i = 0; i < 12; i++) begin
            step(pat[i]);
            chk("s2_press_at_9", press, i == 8);
        end
        repeat (10) step(0);
        // long press
        for (int i = 1; i <= 40; i++) begin
            step(1);
            chk("s3_long_at_26", long_press, i == 26);
        end
        repeat (10) step(0);
        // release bounce while held delays long_press
        for (int i = 1; i <= 45; i++) begin
            step(!(i == 11 || i == 12));
            chk("s4_level", level, i >= 6);
            chk("s4_long_at_29", long_press, i == 29);
            chk("s4_no_release", released, 1'b0);
        end
        repeat (10) step(0);
        // short tap
        for (int i = 1; i <= 13; i++) begin
            step(i <= 3);
            chk("s5_level", level, 1'b0);
            chk("s5_press", press, 1'b0);
        end
        // reset while pressed
        repeat (10) step(1);
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step(1);
            chk("s6_press_at_6", press, i == 6);
            chk("s6_no_release", released, 1'b0);
        end
        repeat (10) step(0);
        // random activity: short glitches, long holds, occasional reset
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 19) == 0) do_reset();
            b = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 1) ? $urandom_range(1, 5) : $urandom_range(4, 40);
            repeat (len) step(b);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
